// File: rtl/wm_write_arbiter_if.sv
// Bundle between the relaxation units and the WorkingMemory write port:
// the request side (req/addr/data/grant) and the registered write bus (WMWE/WMWAR/WMWDR).
//
// Handshake: a requester raises req[i] with its addr/data stable and holds all three
// until it samples grant[i]=1 at a rising edge; that edge is the transfer. It may drop
// req[i] before a grant, which discards the word. req must not depend combinationally
// on grant.
interface wm_write_arbiter_if #(
  parameter int NREQ = 4,
  parameter int AW   = 13,
  parameter int DW   = 128
);
  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    grant;
  logic               WMWE;
  logic [AW-1:0]      WMWAR;
  logic [DW-1:0]      WMWDR;

  modport master (
    output req, req_addr, req_data,
    input  grant, WMWE, WMWAR, WMWDR
  );

  modport slave (
    input  req, req_addr, req_data,
    output grant, WMWE, WMWAR, WMWDR
  );
endinterface

// File: rtl/wm_write_arbiter.sv
// Round-robin arbiter sharing the single WorkingMemory write port among NREQ
// relaxation units; also tracks whether any write happened (changed / wr_count).
module wm_write_arbiter #(
  parameter int  NREQ = 4,
  parameter int  AW   = 13,
  parameter int  DW   = 128,
  parameter int  CW   = 16,
  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          en,
  input  logic          clr,
  wm_write_arbiter_if.slave bus,
  output logic          changed,
  output logic [CW-1:0] wr_count,
  output logic          idle,
  output logic [PW-1:0] ptr
);

  logic          found;
  logic          granted;
  logic [PW-1:0] win_idx;
  logic [PW:0]   cand;
  logic [NREQ-1:0] grant_vec;
  logic [PW-1:0] ptr_next;

  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] data_q;

  // Search from ptr upward, wrapping modulo NREQ; the first active request wins.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr} + (PW+1)'(k);
      if (cand >= (PW+1)'(NREQ)) cand = cand - (PW+1)'(NREQ);
      if (!found && bus.req[cand[PW-1:0]]) begin
        found   = 1'b1;
        win_idx = cand[PW-1:0];
      end
    end
  end

  always_comb begin
    granted   = reset && en && found;
    grant_vec = '0;
    if (granted) grant_vec[win_idx] = 1'b1;
    ptr_next  = (win_idx == PW'(NREQ-1)) ? '0 : win_idx + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      ptr    <= '0;
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else if (granted) begin
      ptr    <= ptr_next;
      we_q   <= 1'b1;
      addr_q <= bus.req_addr[win_idx*AW +: AW];
      data_q <= bus.req_data[win_idx*DW +: DW];
    end else begin
      we_q   <= 1'b0;
    end
  end

  // A grant on the same edge as clr wins: the cleared count restarts at one.
  always_ff @(posedge clock) begin
    if (!reset) begin
      changed  <= 1'b0;
      wr_count <= '0;
    end else if (granted) begin
      changed <= 1'b1;
      if (clr)             wr_count <= CW'(1);
      else if (!(&wr_count)) wr_count <= wr_count + 1'b1;
    end else if (clr) begin
      changed  <= 1'b0;
      wr_count <= '0;
    end
  end

  assign bus.grant = grant_vec;
  assign bus.WMWE  = we_q;
  assign bus.WMWAR = addr_q;
  assign bus.WMWDR = data_q;
  assign idle      = (bus.req == '0) && !we_q;

endmodule

// File: tb/tb_wm_write_arbiter.sv
// Directed and randomized checks of wm_write_arbiter against a cycle-level
// reference model of the round-robin grant, write bus and change tracking.
module tb_wm_write_arbiter;
  localparam int NREQ = 4;
  localparam int AW   = 13;
  localparam int DW   = 128;
  localparam int CW   = 4;
  localparam int PW   = 2;

  logic          clock = 1'b0;
  logic          reset, en, clr;
  logic          changed, idle;
  logic [CW-1:0] wr_count;
  logic [PW-1:0] ptr;

  int errors = 0;
  int checks = 0;

  // model state
  int           m_ptr = 0;
  logic         m_we = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;
  logic         m_changed = 1'b0;
  int           m_cnt = 0;
  logic [AW+DW-1:0] exp_q[$];

  // random requester state
  logic          pend [NREQ];
  logic [AW-1:0] r_addr [NREQ];
  logic [DW-1:0] r_data [NREQ];

  wm_write_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

  wm_write_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .CW(CW)) dut (
    .clock    (clock),
    .reset    (reset),
    .en       (en),
    .clr      (clr),
    .bus      (bus.slave),
    .changed  (changed),
    .wr_count (wr_count),
    .idle     (idle),
    .ptr      (ptr)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One clock: check grant/idle mid-cycle, advance model at the edge, check registers after it.
  task automatic step(input string tag, output int gi);
    int w;
    logic [NREQ-1:0] eg;
    logic [AW+DW-1:0] wr;
    @(negedge clock);
    w = -1;
    if (reset && en)
      for (int k = 0; k < NREQ; k++)
        if (w < 0 && bus.req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
    eg = '0;
    if (w >= 0) eg[w] = 1'b1;
    check($sformatf("%s grant", tag), DW'(bus.grant), DW'(eg));
    check($sformatf("%s idle", tag), DW'(idle), DW'((bus.req == '0) && !m_we));
    if (w >= 0) exp_q.push_back({bus.req_addr[w*AW +: AW], bus.req_data[w*DW +: DW]});
    @(posedge clock);
    if (!reset) begin
      m_ptr = 0; m_we = 1'b0; m_addr = '0; m_data = '0; m_changed = 1'b0; m_cnt = 0;
      exp_q.delete();
    end else if (w >= 0) begin
      wr = exp_q.pop_front();
      m_we = 1'b1; m_addr = wr[AW+DW-1:DW]; m_data = wr[DW-1:0];
      m_ptr = (w + 1) % NREQ;
      m_changed = 1'b1;
      m_cnt = clr ? 1 : ((m_cnt + 1 > (1 << CW) - 1) ? (1 << CW) - 1 : m_cnt + 1);
    end else begin
      m_we = 1'b0;
      if (clr) begin m_changed = 1'b0; m_cnt = 0; end
    end
    #1;
    check($sformatf("%s WMWE", tag), DW'(bus.WMWE), DW'(m_we));
    check($sformatf("%s WMWAR", tag), DW'(bus.WMWAR), DW'(m_addr));
    check($sformatf("%s WMWDR", tag), bus.WMWDR, m_data);
    check($sformatf("%s changed", tag), DW'(changed), DW'(m_changed));
    check($sformatf("%s wr_count", tag), DW'(wr_count), DW'(m_cnt));
    check($sformatf("%s ptr", tag), DW'(ptr), DW'(m_ptr));
    gi = w;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req[i] = 1'b1;
    bus.req_addr[i*AW +: AW] = a;
    bus.req_data[i*DW +: DW] = d;
  endtask

  initial begin
    int gi;
    int seq [8];
    reset = 1'b0; en = 1'b0; clr = 1'b0;
    bus.req = '0; bus.req_addr = '0; bus.req_data = '0;
    repeat (2) @(posedge clock);
    #1;

    // reset release, idle bus
    reset = 1'b1; en = 1'b1;
    for (int c = 0; c < 5; c++) step("idle", gi);
    check("idle_flag", DW'(idle), DW'(1));

    // single request
    set_req(0, 13'h005, 128'h2A);
    step("single", gi);
    check("single_winner", DW'(gi), DW'(0));
    bus.req = '0;
    step("single_wr", gi);
    check("single_addr", DW'(bus.WMWAR), DW'(13'h005));
    check("single_data", bus.WMWDR, 128'h2A);
    check("single_cnt", DW'(wr_count), DW'(1));

    // all four from ptr=0
    reset = 1'b0;
    step("rst_a", gi);
    reset = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, AW'(16 + i), DW'(100 + i));
    for (int c = 0; c < 8; c++) begin
      step("rr", gi);
      seq[c] = gi;
      bus.req_data[gi*DW +: DW] = rand_word();
    end
    for (int c = 0; c < 8; c++) check($sformatf("rr_seq%0d", c), DW'(seq[c]), DW'(c % 4));
    bus.req = '0;
    step("rr_tail", gi);
    check("rr_cnt", DW'(wr_count), DW'(8));

    // en gating
    en = 1'b0;
    set_req(1, 13'h011, 128'h11);
    set_req(3, 13'h033, 128'h33);
    for (int c = 0; c < 3; c++) step("en0", gi);
    en = 1'b1;
    step("en1_a", gi);
    check("en1_first", DW'(gi), DW'(1));
    bus.req[1] = 1'b0;
    step("en1_b", gi);
    check("en1_second", DW'(gi), DW'(3));
    bus.req = '0;

    // clr with and without grant
    set_req(2, 13'h022, 128'h22);
    clr = 1'b1;
    step("clr_g", gi);
    check("clr_g_changed", DW'(changed), DW'(1));
    check("clr_g_cnt", DW'(wr_count), DW'(1));
    bus.req = '0;
    step("clr_n", gi);
    check("clr_n_changed", DW'(changed), DW'(0));
    check("clr_n_cnt", DW'(wr_count), DW'(0));
    clr = 1'b0;

    // saturation of wr_count
    for (int i = 0; i < NREQ; i++) set_req(i, AW'(i), DW'(i));
    for (int c = 0; c < 20; c++) step("sat", gi);
    check("sat_cnt", DW'(wr_count), DW'((1 << CW) - 1));
    bus.req = '0;

    // reset mid-stream with 2 and 3 pending
    set_req(0, 13'h100, 128'h100);
    step("mid", gi);
    bus.req[0] = 1'b0;
    set_req(2, 13'h200, 128'h200);
    set_req(3, 13'h300, 128'h300);
    reset = 1'b0;
    step("mid_rst", gi);
    check("mid_rst_we", DW'(bus.WMWE), DW'(0));
    check("mid_rst_ptr", DW'(ptr), DW'(0));
    check("mid_rst_cnt", DW'(wr_count), DW'(0));
    reset = 1'b1;
    step("mid_rel", gi);
    check("mid_rel_first", DW'(gi), DW'(2));
    bus.req = '0;

    // randomized traffic
    for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          r_addr[i] = AW'($urandom);
          r_data[i] = rand_word();
        end else if (pend[i] && $urandom_range(0, 19) == 0) begin
          pend[i] = 1'b0;
        end
        bus.req[i] = pend[i];
        bus.req_addr[i*AW +: AW] = r_addr[i];
        bus.req_data[i*DW +: DW] = r_data[i];
      end
      en    = ($urandom_range(0, 7) != 0);
      clr   = ($urandom_range(0, 15) == 0);
      reset = ($urandom_range(0, 59) != 0);
      step("rand", gi);
      if (gi >= 0) pend[gi] = 1'b0;
    end
    reset = 1'b1; en = 1'b1; clr = 1'b0; bus.req = '0;
    step("drain", gi);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wm_write_arbiter.md
# wm_write_arbiter

Round-robin arbiter that shares the single write port of the Bellman-Ford working memory (SRAM_2R1W, 13-bit address, 128-bit word) among NREQ relaxation units. It grants at most one request per cycle, registers the winning address/data onto the memory write port, and tracks whether any distance word was written. The iteration controller uses the `changed` flag for early termination and `idle` for pass boundaries. It sits between the relaxation datapaths and the WorkingMemory write bus (WMWE/WMWAR/WMWDR).

## Interface
- NREQ, 4: number of requesters, 2..8
- AW, 13: working-memory address width
- DW, 128: working-memory data width
- CW, 16: write-counter width

- clock  in  1  system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-low reset (asserted when 0, sampled on the rising edge of clock)
- en  in  1  grant enable; when 0, no new grants are issued
- clr  in  1  synchronous clear of `changed` and `wr_count`
- req  in  NREQ  per-requester write request
- req_addr  in  NREQ*AW  packed addresses; requester i uses bits [i*AW +: AW]
- req_data  in  NREQ*DW  packed data; requester i uses bits [i*DW +: DW]
- grant  out  NREQ  one-hot or zero, combinational; grant[i]=1 means requester i is accepted at this edge
- WMWE  out  1  registered write enable to WorkingMemory
- WMWAR  out  AW  registered write address
- WMWDR  out  DW  registered write data
- changed  out  1  sticky flag; 1 once any write has been issued since the last clr or reset
- wr_count  out  CW  number of writes issued since the last clr or reset, saturating
- idle  out  1  combinational; 1 when req==0 and WMWE==0

## Operation
- Round-robin pointer `ptr` in range 0..NREQ-1. Priority search runs from ptr upward and wraps modulo NREQ. The first requester i with req[i]=1 wins.
- grant[i] = reset & en & winner==i. grant is all-zero when en=0, when reset is asserted, or when req==0.
- On an edge where grant[i]=1:
  - WMWE<=1
  - WMWAR<=req_addr[i]
  - WMWDR<=req_data[i]
  - ptr<=(i+1) mod NREQ
- On an edge with no grant: WMWE<=0. WMWAR and WMWDR hold their values. ptr holds.
- Handshake: a requester asserts req with addr/data stable and holds all three until it samples grant[i]=1 at a rising edge. It deasserts req the following cycle unless it has a new word. Dropping req before grant is legal; that request is discarded with no write.
- Multiple requesters targeting the same address are serialized in round-robin order. Last writer wins. No merging or min-compare is done here.
- changed: set to 1 on any granted edge. clr=1 clears it. If a grant and clr occur on the same edge, changed=1 (set wins).
- wr_count: +1 per granted edge and saturates at 2^CW-1. clr=1 clears it. If a grant and clr occur on the same edge, wr_count=1.
- Reset (reset=0 at an edge): ptr=0, WMWE=0, WMWAR=0, WMWDR=0, changed=0, wr_count=0.
  - Reset has priority over clr and grants.
  - A write registered in the cycle before reset is still presented on WMWE for that cycle; a write not yet granted is lost.
- Outputs after reset: grant=0 while reset=0; idle=1 when req==0.

## Timing
- Acceptance: request accepted at edge k (grant[i]=1 in cycle k-1 → k). WMWE=1 during cycle k. The memory write commits at edge k+1, so it is visible on the WorkingMemory read ports from cycle k+1.
- Throughput: one write per cycle sustained.
- Worst-case wait with all requesters continuously active: NREQ-1 cycles.
- grant depends combinationally on req, en, reset and ptr. Requesters must not make req depend combinationally on grant.
- idle falls in the same cycle req rises. It returns to 1 one cycle after the last grant, provided req==0.

## Test plan
- Reset release, req=0, en=1: grant=0, WMWE=0, idle=1, changed=0, wr_count=0 for 5 cycles.
- Single request: req=4'b0001, addr=13'h005, data=128'h2A held until grant → grant[0]=1 for one cycle. Next cycle WMWE=1, WMWAR=13'h005, WMWDR=128'h2A. changed=1, wr_count=1.
- All four requesters held continuously for 8 cycles from ptr=0: grant sequence 0,1,2,3,0,1,2,3; wr_count=8; WMWE high 8 consecutive cycles.
- en=0 with req=4'b1010 for 3 cycles: no grant, WMWE=0. Then en=1: grant[1] first, then grant[3].
- clr on the same edge as a grant: changed=1, wr_count=1. clr with no grant: changed=0, wr_count=0.
- reset=0 asserted mid-stream while requesters 2 and 3 are pending: at the next edge WMWE=0, ptr=0, wr_count=0. After release with req=4'b1100, grant[2] is issued first.
